// File: rtl/cep_define.sv
// Shared definitions for the PMP CSR file: CSR base numbers, field encodings
// and the layout of one PMP configuration byte.
package cep_define;

  localparam logic [11:0] PMPCFG_BASE  = 12'h3A0;
  localparam logic [11:0] PMPADDR_BASE = 12'h3B0;

  // Address-matching mode held in bits 4:3 of each configuration byte.
  typedef enum logic [1:0] {
    A_OFF   = 2'd0,
    A_TOR   = 2'd1,
    A_NA4   = 2'd2,
    A_NAPOT = 2'd3
  } pmp_a_e;

  // Request operation carried on csr_op.
  typedef enum logic [1:0] {
    OP_READ  = 2'd0,
    OP_WRITE = 2'd1,
    OP_SET   = 2'd2,
    OP_CLEAR = 2'd3
  } csr_op_e;

  // One PMP configuration byte, MSB first.
  typedef struct packed {
    logic       l;
    logic [1:0] rsvd;
    pmp_a_e     a;
    logic       x;
    logic       w;
    logic       r;
  } pmp_cfg_t;

endpackage

// File: rtl/pmp_cfg_legalize.sv
// Legalizes one configuration byte: locked bytes and the reserved R=0/W=1
// combination keep the old value; otherwise the reserved bits are cleared.
module pmp_cfg_legalize
  import cep_define::*;
(
  input  logic [7:0] old_byte,
  input  logic [7:0] cand_byte,
  output logic [7:0] new_byte
);

  pmp_cfg_t old_s;
  pmp_cfg_t cand_s;
  pmp_cfg_t res_s;

  assign old_s    = pmp_cfg_t'(old_byte);
  assign cand_s   = pmp_cfg_t'(cand_byte);
  assign new_byte = res_s;

  // Pick old byte or cleaned-up candidate for this lane.
  always_comb begin
    res_s = old_s;
    if (old_s.l) begin
      res_s = old_s;
    end else if (!cand_s.r && cand_s.w) begin
      res_s = old_s;
    end else begin
      res_s      = cand_s;
      res_s.rsvd = 2'b00;
    end
  end

endmodule

// File: rtl/pmp_csr_file.sv
// PMP configuration and address CSR file. Every request is answered one
// cycle later with the pre-update value; updates commit on the same edge.
module pmp_csr_file
  import cep_define::*;
#(
  parameter int NUM_ENTRIES = 16,
  parameter int GRAN        = 0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     csr_valid,
  input  logic [1:0]               csr_op,
  input  logic [11:0]              csr_addr,
  input  logic [31:0]              csr_wdata,
  input  logic [1:0]               priv_mode,
  output logic                     csr_rvalid,
  output logic [31:0]              csr_rdata,
  output logic                     csr_illegal,
  output logic [NUM_ENTRIES*8-1:0] pmpcfg_flat,
  output logic [NUM_ENTRIES*32-1:0] pmpaddr_flat,
  output logic                     pmp_changed
);

  localparam int NUM_CFG = NUM_ENTRIES / 4;
  localparam int IW      = $clog2(NUM_ENTRIES);
  // Bits hidden as zero for OFF/TOR and forced to one for NAPOT.
  localparam logic [31:0] CLR_MASK = (GRAN >= 1) ? ((32'd1 << GRAN) - 32'd1) : 32'd0;
  localparam int          NSH      = (GRAN >= 2) ? (GRAN - 1) : 0;
  localparam logic [31:0] SET_MASK = (32'd1 << NSH) - 32'd1;

  logic [7:0]  cfg_r  [NUM_ENTRIES];
  logic [31:0] addr_r [NUM_ENTRIES];

  logic [11:0]   cfg_off_s;
  logic [11:0]   addr_off_s;
  logic          is_cfg_s;
  logic          is_addr_s;
  logic          legal_s;
  logic [IW-1:0] ent_base_s;
  logic [IW-1:0] addr_idx_s;
  logic [IW-1:0] lane_idx_s  [4];
  logic [7:0]    lane_old_s  [4];
  logic [7:0]    lane_cand_s [4];
  logic [7:0]    lane_new_s  [4];
  logic [31:0]   old_cfg_word_s;
  logic [31:0]   cand_cfg_word_s;
  logic [31:0]   new_cfg_word_s;
  logic [31:0]   old_addr_s;
  logic [31:0]   cand_addr_s;
  logic [NUM_ENTRIES-1:0] addr_lock_s;

  logic          cfg_we_s;
  logic          addr_we_s;
  logic          changed_s;
  logic [31:0]   rdata_nxt_s;

  // Candidate value produced by an operation on an old register value.
  function automatic logic [31:0] apply_op(input logic [1:0] op,
                                           input logic [31:0] old_v,
                                           input logic [31:0] wd_v);
    logic [31:0] res_v;
    case (csr_op_e'(op))
      OP_WRITE: res_v = wd_v;
      OP_SET:   res_v = old_v | wd_v;
      OP_CLEAR: res_v = old_v & ~wd_v;
      default:  res_v = old_v;
    endcase
    return res_v;
  endfunction

  // Software-visible form of a stored address, shaped by the entry's A field.
  function automatic logic [31:0] addr_view(input logic [31:0] v,
                                            input logic [1:0]  a);
    logic [31:0] res_v;
    case (pmp_a_e'(a))
      A_OFF, A_TOR: res_v = v & ~CLR_MASK;
      A_NAPOT:      res_v = v | SET_MASK;
      default:      res_v = v;
    endcase
    return res_v;
  endfunction

  // Offsets wrap for numbers below the base, so one unsigned compare suffices.
  assign cfg_off_s  = csr_addr - PMPCFG_BASE;
  assign addr_off_s = csr_addr - PMPADDR_BASE;
  assign is_cfg_s   = (cfg_off_s < 12'(NUM_CFG));
  assign is_addr_s  = (addr_off_s < 12'(NUM_ENTRIES));
  assign legal_s    = csr_valid && (priv_mode == 2'b00) && (is_cfg_s || is_addr_s);
  assign ent_base_s = IW'({cfg_off_s, 2'b00});
  assign addr_idx_s = addr_off_s[IW-1:0];

  assign old_cfg_word_s  = {lane_old_s[3], lane_old_s[2], lane_old_s[1], lane_old_s[0]};
  assign cand_cfg_word_s = apply_op(csr_op, old_cfg_word_s, csr_wdata);
  assign new_cfg_word_s  = {lane_new_s[3], lane_new_s[2], lane_new_s[1], lane_new_s[0]};
  assign old_addr_s      = addr_r[addr_idx_s];
  assign cand_addr_s     = apply_op(csr_op, old_addr_s, csr_wdata);

  genvar gj;
  generate
    for (gj = 0; gj < 4; gj++) begin : g_lane
      assign lane_idx_s[gj]  = ent_base_s + IW'(gj);
      assign lane_old_s[gj]  = cfg_r[lane_idx_s[gj]];
      assign lane_cand_s[gj] = cand_cfg_word_s[8*gj +: 8];
      pmp_cfg_legalize u_legalize (
        .old_byte  (lane_old_s[gj]),
        .cand_byte (lane_cand_s[gj]),
        .new_byte  (lane_new_s[gj])
      );
    end
  endgenerate

  genvar gi;
  generate
    for (gi = 0; gi < NUM_ENTRIES; gi++) begin : g_entry
      // An address is frozen by its own lock or by a locked TOR entry above it.
      if (gi + 1 < NUM_ENTRIES) begin : g_tor
        assign addr_lock_s[gi] = cfg_r[gi][7] |
                                 (cfg_r[gi+1][7] & (cfg_r[gi+1][4:3] == 2'(A_TOR)));
      end else begin : g_last
        assign addr_lock_s[gi] = cfg_r[gi][7];
      end
      assign pmpcfg_flat[8*gi +: 8]   = cfg_r[gi];
      assign pmpaddr_flat[32*gi +: 32] = addr_r[gi];
    end
  endgenerate

  // Decide read data and whether this request changes any stored register.
  always_comb begin
    rdata_nxt_s = 32'd0;
    cfg_we_s    = 1'b0;
    addr_we_s   = 1'b0;
    if (legal_s && is_cfg_s) begin
      rdata_nxt_s = old_cfg_word_s;
      cfg_we_s    = (csr_op != 2'(OP_READ)) && (new_cfg_word_s != old_cfg_word_s);
    end else if (legal_s && is_addr_s) begin
      rdata_nxt_s = addr_view(old_addr_s, cfg_r[addr_idx_s][4:3]);
      addr_we_s   = (csr_op != 2'(OP_READ)) && !addr_lock_s[addr_idx_s] &&
                    (cand_addr_s != old_addr_s);
    end else begin
      rdata_nxt_s = 32'd0;
    end
    changed_s = cfg_we_s | addr_we_s;
  end

  // Commit register updates and register the response for the next cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        cfg_r[i]  <= 8'd0;
        addr_r[i] <= 32'd0;
      end
      csr_rvalid  <= 1'b0;
      csr_illegal <= 1'b0;
      csr_rdata   <= 32'd0;
      pmp_changed <= 1'b0;
    end else begin
      if (cfg_we_s) begin
        for (int j = 0; j < 4; j++) begin
          cfg_r[lane_idx_s[j]] <= lane_new_s[j];
        end
      end
      if (addr_we_s) begin
        addr_r[addr_idx_s] <= cand_addr_s;
      end
      csr_rvalid  <= csr_valid;
      csr_illegal <= csr_valid && !legal_s;
      csr_rdata   <= rdata_nxt_s;
      pmp_changed <= changed_s;
    end
  end

endmodule

// File: tb/tb_pmp_csr_file.sv
// Directed self-checking bench for pmp_csr_file (16 entries, granularity 2).
module tb_pmp_csr_file;

  localparam int NE = 16;

  logic           clock;
  logic           reset;
  logic           csr_valid;
  logic [1:0]     csr_op;
  logic [11:0]    csr_addr;
  logic [31:0]    csr_wdata;
  logic [1:0]     priv_mode;
  logic           csr_rvalid;
  logic [31:0]    csr_rdata;
  logic           csr_illegal;
  logic [NE*8-1:0]  pmpcfg_flat;
  logic [NE*32-1:0] pmpaddr_flat;
  logic           pmp_changed;

  int n_checks;
  int n_fail;

  logic        r_valid;
  logic [31:0] r_data;
  logic        r_ill;
  logic        r_chg;

  pmp_csr_file #(.NUM_ENTRIES(NE), .GRAN(2)) dut (
    .clock        (clock),
    .reset        (reset),
    .csr_valid    (csr_valid),
    .csr_op       (csr_op),
    .csr_addr     (csr_addr),
    .csr_wdata    (csr_wdata),
    .priv_mode    (priv_mode),
    .csr_rvalid   (csr_rvalid),
    .csr_rdata    (csr_rdata),
    .csr_illegal  (csr_illegal),
    .pmpcfg_flat  (pmpcfg_flat),
    .pmpaddr_flat (pmpaddr_flat),
    .pmp_changed  (pmp_changed)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // One request; response captured 1 time unit after the accepting edge.
  task automatic req(input logic [1:0] op, input logic [11:0] addr,
                     input logic [31:0] wd, input logic [1:0] pm);
    @(negedge clock);
    csr_valid = 1'b1; csr_op = op; csr_addr = addr; csr_wdata = wd; priv_mode = pm;
    @(posedge clock);
    #1;
    r_valid = csr_rvalid; r_data = csr_rdata; r_ill = csr_illegal; r_chg = pmp_changed;
    csr_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    csr_valid = 1'b1; csr_op = 2'd1; csr_addr = 12'h3A0; csr_wdata = 32'h0000_00FF; priv_mode = 2'b00;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0; csr_valid = 1'b0;
    @(posedge clock); #1;
    n_checks++; if (csr_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid: got %b want 0", csr_rvalid); end
    n_checks++; if (csr_rdata !== 32'd0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", csr_rdata); end
    n_checks++; if (csr_illegal !== 1'b0 || pmp_changed !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got ill=%b chg=%b want 0 0", csr_illegal, pmp_changed); end
    n_checks++; if (pmpcfg_flat !== '0) begin n_fail++; $display("FAIL reset_cfg: got %h want 0", pmpcfg_flat); end
    n_checks++; if (pmpaddr_flat !== '0) begin n_fail++; $display("FAIL reset_addr: got nonzero want 0"); end
  endtask

  task automatic test_cfg_write();
    req(2'd1, 12'h3A0, 32'h0000_0F0F, 2'b00);
    n_checks++; if (r_valid !== 1'b1 || r_ill !== 1'b0) begin n_fail++; $display("FAIL cfgw_resp: got v=%b ill=%b want 1 0", r_valid, r_ill); end
    n_checks++; if (r_data !== 32'd0) begin n_fail++; $display("FAIL cfgw_old: got %h want 0", r_data); end
    n_checks++; if (r_chg !== 1'b1) begin n_fail++; $display("FAIL cfgw_chg: got %b want 1", r_chg); end
    req(2'd0, 12'h3A0, 32'd0, 2'b00);
    n_checks++; if (r_data !== 32'h0000_0F0F) begin n_fail++; $display("FAIL cfgr_data: got %h want 00000f0f", r_data); end
    n_checks++; if (r_chg !== 1'b0) begin n_fail++; $display("FAIL cfgr_chg: got %b want 0", r_chg); end
  endtask

  task automatic test_lock();
    req(2'd1, 12'h3A0, 32'h0000_0080, 2'b00);
    n_checks++; if (pmpcfg_flat[31:0] !== 32'h0000_0080) begin n_fail++; $display("FAIL lock_set: got %h want 00000080", pmpcfg_flat[31:0]); end
    req(2'd1, 12'h3A0, 32'h0303_0303, 2'b00);
    n_checks++; if (r_data !== 32'h0000_0080 || r_chg !== 1'b1) begin n_fail++; $display("FAIL lock_w2: got %h chg=%b want 00000080 1", r_data, r_chg); end
    req(2'd0, 12'h3A0, 32'd0, 2'b00);
    n_checks++; if (r_data !== 32'h0303_0380) begin n_fail++; $display("FAIL lock_bytes: got %h want 03030380", r_data); end
    req(2'd1, 12'h3B0, 32'h0000_1234, 2'b00);
    n_checks++; if (pmpaddr_flat[31:0] !== 32'd0 || r_chg !== 1'b0) begin n_fail++; $display("FAIL lock_addr0: got %h chg=%b want 0 0", pmpaddr_flat[31:0], r_chg); end
    req(2'd3, 12'h3A0, 32'hFFFF_FFFF, 2'b00);
    n_checks++; if (pmpcfg_flat[31:0] !== 32'h0000_0080) begin n_fail++; $display("FAIL lock_sticky: got %h want 00000080", pmpcfg_flat[31:0]); end
  endtask

  task automatic test_tor_lock();
    req(2'd1, 12'h3A1, 32'h0000_8800, 2'b00);
    n_checks++; if (pmpcfg_flat[47:40] !== 8'h88 || r_chg !== 1'b1) begin n_fail++; $display("FAIL tor_cfg5: got %h chg=%b want 88 1", pmpcfg_flat[47:40], r_chg); end
    req(2'd1, 12'h3B4, 32'h0000_FFFF, 2'b00);
    n_checks++; if (pmpaddr_flat[4*32 +: 32] !== 32'd0 || r_chg !== 1'b0) begin n_fail++; $display("FAIL tor_addr4: got %h chg=%b want 0 0", pmpaddr_flat[4*32 +: 32], r_chg); end
    req(2'd1, 12'h3B6, 32'h0000_FFFF, 2'b00);
    n_checks++; if (pmpaddr_flat[6*32 +: 32] !== 32'h0000_FFFF || r_chg !== 1'b1) begin n_fail++; $display("FAIL tor_addr6: got %h chg=%b want 0000ffff 1", pmpaddr_flat[6*32 +: 32], r_chg); end
    req(2'd0, 12'h3B6, 32'd0, 2'b00);
    n_checks++; if (r_data !== 32'h0000_FFFC) begin n_fail++; $display("FAIL tor_view6: got %h want 0000fffc", r_data); end
  endtask

  task automatic test_legalize();
    req(2'd1, 12'h3A2, 32'h0000_0002, 2'b00);
    n_checks++; if (pmpcfg_flat[71:64] !== 8'h00 || r_chg !== 1'b0) begin n_fail++; $display("FAIL leg_rw10: got %h chg=%b want 00 0", pmpcfg_flat[71:64], r_chg); end
    req(2'd1, 12'h3A2, 32'h0000_0061, 2'b00);
    n_checks++; if (pmpcfg_flat[71:64] !== 8'h01 || r_chg !== 1'b1) begin n_fail++; $display("FAIL leg_rsvd: got %h chg=%b want 01 1", pmpcfg_flat[71:64], r_chg); end
    req(2'd1, 12'h3A2, 32'h0000_0203, 2'b00);
    n_checks++; if (pmpcfg_flat[95:64] !== 32'h0000_0003) begin n_fail++; $display("FAIL leg_mix: got %h want 00000003", pmpcfg_flat[95:64]); end
  endtask

  task automatic test_gran();
    req(2'd1, 12'h3B3, 32'hFFFF_FFF0, 2'b00);
    req(2'd1, 12'h3A0, 32'h1900_0000, 2'b00);
    req(2'd0, 12'h3B3, 32'd0, 2'b00);
    n_checks++; if (r_data !== 32'hFFFF_FFF1) begin n_fail++; $display("FAIL gran_napot: got %h want fffffff1", r_data); end
    req(2'd1, 12'h3A0, 32'h0900_0000, 2'b00);
    req(2'd0, 12'h3B3, 32'd0, 2'b00);
    n_checks++; if (r_data !== 32'hFFFF_FFF0) begin n_fail++; $display("FAIL gran_tor: got %h want fffffff0", r_data); end
    req(2'd1, 12'h3A0, 32'h0100_0000, 2'b00);
    req(2'd2, 12'h3B3, 32'h0000_0003, 2'b00);
    n_checks++; if (pmpaddr_flat[3*32 +: 32] !== 32'hFFFF_FFF3) begin n_fail++; $display("FAIL gran_stored: got %h want fffffff3", pmpaddr_flat[3*32 +: 32]); end
    req(2'd0, 12'h3B3, 32'd0, 2'b00);
    n_checks++; if (r_data !== 32'hFFFF_FFF0) begin n_fail++; $display("FAIL gran_off: got %h want fffffff0", r_data); end
  endtask

  task automatic test_illegal();
    req(2'd0, 12'h3B6, 32'd0, 2'b01);
    n_checks++; if (r_valid !== 1'b1 || r_ill !== 1'b1 || r_data !== 32'd0) begin n_fail++; $display("FAIL ill_priv: got v=%b ill=%b d=%h want 1 1 0", r_valid, r_ill, r_data); end
    req(2'd1, 12'h3B6, 32'h1111_1111, 2'b10);
    n_checks++; if (pmpaddr_flat[6*32 +: 32] !== 32'h0000_FFFF || r_chg !== 1'b0 || r_ill !== 1'b1) begin n_fail++; $display("FAIL ill_uwrite: got %h chg=%b ill=%b want 0000ffff 0 1", pmpaddr_flat[6*32 +: 32], r_chg, r_ill); end
    req(2'd0, 12'h3C0, 32'd0, 2'b00);
    n_checks++; if (r_ill !== 1'b1 || r_data !== 32'd0) begin n_fail++; $display("FAIL ill_addr_hi: got ill=%b d=%h want 1 0", r_ill, r_data); end
    req(2'd0, 12'h3A4, 32'd0, 2'b00);
    n_checks++; if (r_ill !== 1'b1) begin n_fail++; $display("FAIL ill_cfg4: got ill=%b want 1", r_ill); end
    req(2'd0, 12'h3A3, 32'd0, 2'b00);
    n_checks++; if (r_ill !== 1'b0 || r_valid !== 1'b1) begin n_fail++; $display("FAIL legal_cfg3: got ill=%b v=%b want 0 1", r_ill, r_valid); end
  endtask

  task automatic test_back_to_back();
    req(2'd1, 12'h3B7, 32'hABCD_0000, 2'b00);
    n_checks++; if (r_data !== 32'd0 || r_chg !== 1'b1) begin n_fail++; $display("FAIL b2b_write: got %h chg=%b want 0 1", r_data, r_chg); end
    req(2'd0, 12'h3B7, 32'd0, 2'b00);
    n_checks++; if (r_data !== 32'hABCD_0000 || r_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_read: got %h v=%b want abcd0000 1", r_data, r_valid); end
    @(posedge clock); #1;
    n_checks++; if (csr_rvalid !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: got %b want 0", csr_rvalid); end
  endtask

  task automatic test_reset_mid();
    req(2'd1, 12'h3B8, 32'h5555_5555, 2'b00);
    @(negedge clock);
    reset = 1'b1;
    csr_valid = 1'b1; csr_op = 2'd1; csr_addr = 12'h3B9; csr_wdata = 32'h7777_7777; priv_mode = 2'b00;
    @(posedge clock); #1;
    n_checks++; if (csr_rvalid !== 1'b0 || csr_illegal !== 1'b0 || csr_rdata !== 32'd0 || pmp_changed !== 1'b0) begin n_fail++; $display("FAIL rst_mid_out: got v=%b ill=%b d=%h chg=%b want all 0", csr_rvalid, csr_illegal, csr_rdata, pmp_changed); end
    n_checks++; if (pmpaddr_flat !== '0 || pmpcfg_flat !== '0) begin n_fail++; $display("FAIL rst_mid_state: got nonzero registers want 0"); end
    @(negedge clock);
    reset = 1'b0; csr_valid = 1'b0;
    @(posedge clock); #1;
    n_checks++; if (csr_rvalid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_noresp: got %b want 0", csr_rvalid); end
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    csr_valid = 1'b0; csr_op = 2'd0; csr_addr = 12'd0; csr_wdata = 32'd0; priv_mode = 2'b00;
    reset = 1'b1;
    test_reset();
    test_cfg_write();
    test_lock();
    test_tor_lock();
    test_legalize();
    test_gran();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pmp_csr_file.md
PMP_CSR_FILE -- requirements
Module: pmp_csr_file

Interface
REQ-001 Parameter NUM_ENTRIES, default 16, number of PMP entries (legal values 4, 8, 16, 32, 64).
REQ-002 Parameter GRAN, default 0, PMP granularity G (legal range 0..30).
REQ-003 Clock and reset: clock input, active on the rising edge; reset input, synchronous, active-high.
REQ-004 Port list, one per line:
  - clock  in  1  system clock
  - reset  in  1  synchronous, active-high reset
  - csr_valid  in  1  CSR request this cycle
  - csr_op  in  2  request op: read / write / set / clear
  - csr_addr  in  12  CSR number
  - csr_wdata  in  32  write, set or clear operand
  - priv_mode  in  2  privilege: 00 = M, 01 = S, 10 = U
  - csr_rvalid  out  1  response strobe
  - csr_rdata  out  32  read data
  - csr_illegal  out  1  request rejected
  - pmpcfg_flat  out  NUM_ENTRIES*8  all configuration bytes; entry i occupies bits [8i+7:8i]
  - pmpaddr_flat  out  NUM_ENTRIES*32  all address registers; entry i occupies bits [32i+31:32i]
  - pmp_changed  out  1  single-cycle pulse after any effective state change

Function
REQ-005 Decode: pmpcfgK is 0x3A0+K for K < NUM_ENTRIES/4; pmpaddrI is 0x3B0+I for I < NUM_ENTRIES. Any other csr_addr SHALL be illegal.
REQ-006 A request with csr_valid=1 SHALL be illegal when priv_mode is not 00.
REQ-007 Every request SHALL be answered exactly 1 cycle later: csr_rvalid=1 for one cycle. Back-to-back requests SHALL be accepted every cycle.
REQ-008 Legal request: csr_rdata SHALL carry the pre-update (old) register value after read-view masking, and csr_illegal=0.
REQ-009 Illegal request: csr_rdata=0, csr_illegal=1, no state change.
REQ-010 Candidate value: write gives wdata; set gives old | wdata; clear gives old & ~wdata; read performs no update.
REQ-011 pmpcfg updates SHALL be applied per byte. A byte whose L bit (bit 7) is 1 SHALL keep its old value; the other bytes in the same CSR still update.
REQ-012 Byte legalization, applied to each byte that is not locked:
  - bits 6:5 are forced to 0;
  - if the candidate has R=0 and W=1 (bits 1:0 = 10), the whole byte keeps its old value.
REQ-013 pmpaddrI SHALL be unwritable if either condition holds:
  - cfg[I].L = 1;
  - I+1 < NUM_ENTRIES, cfg[I+1].L = 1 and cfg[I+1].A = TOR.
REQ-014 Read view of pmpaddrI, driven by cfg[I].A (bits 4:3):
  - GRAN >= 1 and A in {OFF, TOR}: bits GRAN-1:0 read as 0;
  - GRAN >= 2 and A = NAPOT: bits GRAN-2:0 read as 1;
  - stored bits are never altered by this masking.
REQ-015 A later request SHALL observe the state committed by an earlier request (write then read on consecutive cycles returns the new value).
REQ-016 pmpcfg_flat and pmpaddr_flat SHALL show the stored registers (not the read view) and update on the same edge as the commit.
REQ-017 pmp_changed SHALL pulse on the cycle after any commit whose stored value differs from the old value. Writes with no effect (locked, equal value or reserved RW=10) SHALL NOT pulse it.
REQ-018 Once set, an L bit SHALL stay set until reset.

Reset
REQ-019 While reset is high, on the clock edge:
  - all cfg and addr registers SHALL become 0;
  - csr_rvalid, csr_illegal, csr_rdata and pmp_changed SHALL become 0;
  - any request in flight SHALL be discarded with no response.
REQ-020 A request presented in the same cycle that reset is asserted SHALL be ignored.

Structure
REQ-021 The cep_define package SHALL hold:
  - the base constants 0x3A0 and 0x3B0;
  - the A-field enum (OFF=0, TOR=1, NA4=2, NAPOT=3);
  - the csr_op enum (read=0, write=1, set=2, clear=3);
  - the pmp_cfg_t packed struct.
REQ-022 Sub-module pmp_cfg_legalize SHALL be combinational. It takes old byte and candidate byte and returns the legalized byte; one instance per configuration byte lane.

Verification
REQ-023 Write pmpcfg0 = 0x0000_0F0F in M-mode, then read it -> csr_rdata=0x0000_0F0F; pmp_changed pulses once.
REQ-024 Write pmpcfg0 = 0x0000_0080 (entry 0 locked), then write pmpcfg0 = 0x0303_0303 -> result 0x0303_0380; write pmpaddr0 = 0x1234 -> pmpaddr0 stays 0.
REQ-025 With cfg[1] = 0x88 (L=1, A=TOR), write pmpaddr0 = 0xFFFF -> unchanged, pmp_changed=0; write pmpaddr2 = 0xFFFF -> stored.
REQ-026 Write a cfg byte with value 0x02 (R=0, W=1) -> byte unchanged, no pmp_changed; write 0x61 -> stored as 0x01.
REQ-027 With GRAN=2, pmpaddr3 = 0xFFFF_FFF0:
  - A=NAPOT reads 0xFFFF_FFF1;
  - A=TOR reads 0xFFFF_FFF0;
  - set on pmpaddr3 with 0x3 and A=OFF reads 0xFFFF_FFF0 while pmpaddr_flat shows 0xFFFF_FFF3.
REQ-028 Read pmpaddr0 with priv_mode=01, or read 0x3B0+NUM_ENTRIES -> csr_illegal=1 and csr_rdata=0 next cycle; reset mid-stream -> no response and all outputs 0.
